// File: rtl/gru_pkg.sv
// Shared definitions for the GRU time-step sequencer:
// weight addresses and controller state encoding.
package gru_pkg;

    localparam int NUM_W = 9;

    localparam logic [3:0] WZ_A = 4'd0;
    localparam logic [3:0] WR_A = 4'd1;
    localparam logic [3:0] WH_A = 4'd2;
    localparam logic [3:0] UZ_A = 4'd3;
    localparam logic [3:0] UR_A = 4'd4;
    localparam logic [3:0] UH_A = 4'd5;
    localparam logic [3:0] BZ_A = 4'd6;
    localparam logic [3:0] BR_A = 4'd7;
    localparam logic [3:0] BH_A = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

endpackage

// File: rtl/gru_seq_ctrl_if.sv
// Sample-in / result-out stream handshakes of the GRU sequencer.
interface gru_seq_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  x_valid;
    logic                  x_ready;
    logic [DATA_WIDTH-1:0] x_data;
    logic                  x_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_h;
    logic                  out_last;

    modport master (
        output x_valid, x_data, x_last, out_ready,
        input  x_ready, out_valid, out_h, out_last
    );

    modport slave (
        input  x_valid, x_data, x_last, out_ready,
        output x_ready, out_valid, out_h, out_last
    );
endinterface

// File: rtl/gru_weight_regfile.sv
// Nine weight/bias registers; writes accepted only in IDLE with a legal
// address, anything else raises a one-cycle cfg_err.
module gru_weight_regfile
    import gru_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              idle,
    input  logic                              cfg_we,
    input  logic [3:0]                        cfg_addr,
    input  logic [DATA_WIDTH-1:0]             cfg_wdata,
    output logic                              cfg_err,
    output logic [NUM_W-1:0][DATA_WIDTH-1:0]  w
);

    logic ok;

    assign ok = idle && (cfg_addr <= BH_A);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w       <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !ok;
            if (cfg_we && ok) begin
                w[cfg_addr] <= cfg_wdata;
            end
        end
    end

endmodule

// File: rtl/gru_seq_ctrl.sv
// Time-step sequencer for an external combinational GRU cell: registers
// operands, waits CELL_LAT cycles, captures h_out and feeds it back.
module gru_seq_ctrl
    import gru_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    FRACT_WIDTH = 5,
    parameter int                    CELL_LAT    = 2,
    parameter int                    STEP_W      = 8,
    parameter logic [DATA_WIDTH-1:0] H_INIT      = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic                  cfg_err,
    gru_seq_ctrl_if.slave         strm,
    output logic [STEP_W-1:0]     step_cnt,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] cell_x,
    output logic [DATA_WIDTH-1:0] cell_h_in,
    output logic [DATA_WIDTH-1:0] cell_wz,
    output logic [DATA_WIDTH-1:0] cell_wr,
    output logic [DATA_WIDTH-1:0] cell_wh,
    output logic [DATA_WIDTH-1:0] cell_uz,
    output logic [DATA_WIDTH-1:0] cell_ur,
    output logic [DATA_WIDTH-1:0] cell_uh,
    output logic [DATA_WIDTH-1:0] cell_bz,
    output logic [DATA_WIDTH-1:0] cell_br,
    output logic [DATA_WIDTH-1:0] cell_bh,
    input  logic [DATA_WIDTH-1:0] cell_h_out
);

    if (CELL_LAT < 1 || CELL_LAT > 15 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_param
        $error("gru_seq_ctrl: illegal CELL_LAT or FRACT_WIDTH");
    end

    state_t                          state;
    state_t                          state_nxt;
    logic [3:0]                      cnt;
    logic                            take;
    logic                            done;
    logic                            ack;
    logic                            x_ready;
    logic                            first;
    logic                            last_reg;
    logic [DATA_WIDTH-1:0]           x_reg;
    logic [DATA_WIDTH-1:0]           h_in;
    logic [DATA_WIDTH-1:0]           h_reg;
    logic [DATA_WIDTH-1:0]           out_h;
    logic                            out_valid;
    logic                            out_last;
    logic [NUM_W-1:0][DATA_WIDTH-1:0] w;

    gru_weight_regfile #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .idle      (state == IDLE),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .w         (w)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A config write in IDLE steals the cycle from sample acceptance.
    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        take      = 1'b0;
        done      = 1'b0;
        ack       = 1'b0;
        unique case (state)
            IDLE: begin
                x_ready = !cfg_we;
                take    = strm.x_valid && !cfg_we;
                if (take) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    done      = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (strm.out_ready) begin
                    ack       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            first     <= 1'b1;
            last_reg  <= 1'b0;
            x_reg     <= '0;
            h_in      <= '0;
            h_reg     <= '0;
            out_h     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            step_cnt  <= '0;
        end else begin
            if (take) begin
                x_reg    <= strm.x_data;
                last_reg <= strm.x_last;
                h_in     <= first ? H_INIT : h_reg;
                cnt      <= 4'(CELL_LAT - 1);
            end else if (state == SETTLE && !done) begin
                cnt <= cnt - 4'd1;
            end
            if (done) begin
                h_reg     <= cell_h_out;
                out_h     <= cell_h_out;
                out_valid <= 1'b1;
                out_last  <= last_reg;
            end
            if (ack) begin
                out_valid <= 1'b0;
                first     <= last_reg;
                step_cnt  <= last_reg ? '0 : step_cnt + 1'b1;
            end
        end
    end

    assign strm.x_ready   = x_ready;
    assign strm.out_valid = out_valid;
    assign strm.out_h     = out_h;
    assign strm.out_last  = out_last;

    assign busy      = (state != IDLE);
    assign cell_x    = x_reg;
    assign cell_h_in = h_in;
    assign cell_wz   = w[WZ_A];
    assign cell_wr   = w[WR_A];
    assign cell_wh   = w[WH_A];
    assign cell_uz   = w[UZ_A];
    assign cell_ur   = w[UR_A];
    assign cell_uh   = w[UH_A];
    assign cell_bz   = w[BZ_A];
    assign cell_br   = w[BR_A];
    assign cell_bh   = w[BH_A];

endmodule
